fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the control sequencer.
- Holds the program counter (PC) and the instruction register (IR), and runs a req/ack handshake to instruction memory.
- Decodes the IR fields (opcode, imm_mode, reg_sel, operand) that feed the sequencer and datapath.
- Acts on the sequencer strobes load_ir, inc_pc, load_pc and pc_sel.

Parameters:
- ADDR_W, 8, PC and instruction-memory address width.
- RESET_PC, 0, PC value after reset.
- TIMEOUT_CYC, 15, max wait cycles for imem_ack; only used with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; one clock; reset is asynchronous and active-low
- reset_n  in  1  asynchronous active-low reset
- load_ir  in  1  start fetch of mem[pc] into IR
- inc_pc  in  1  increment PC (with load_ir: applied at fetch completion)
- load_pc  in  1  jump request, target = operand
- pc_sel  in  1  0 = unconditional jump; 1 = jump only if zero_flag==0
- zero_flag  in  1  Z flag from flags register
- imem_addr  out  ADDR_W  instruction memory address
- imem_req  out  1  fetch request
- imem_ack  in  1  read data valid
- imem_rdata  in  16  instruction word
- pc  out  ADDR_W  current PC
- opcode  out  4  IR[15:12]
- imm_mode  out  1  IR[11]
- reg_sel  out  3  IR[10:8]
- operand  out  8  IR[7:0]
- ir_valid  out  1  IR holds a completed fetch
- stall  out  1  sequencer must hold its state
- fetch_err  out  1  sticky timeout flag (0 when feature absent)

Behaviour:
- Reset values (async, reset_n=0):
  - pc=RESET_PC, IR=16'h0000, so opcode=NOP.
  - imem_req=0, ir_valid=0, fetch_err=0, FSM=IDLE.
  - The pending-increment flag is cleared.
- FSM states: IDLE, WAIT.
- IDLE, load_ir=1:
  - Go to WAIT; imem_req goes high next cycle (registered).
  - imem_addr=pc is registered at the same edge.
  - inc_pc is captured into a pending-increment flag.
- WAIT, imem_ack=1:
  - IR<=imem_rdata and ir_valid<=1.
  - pc<=pc+1 if pending-increment is set.
  - imem_req<=0; return to IDLE.
- Handshake:
  - imem_req stays high and imem_addr stays stable until the cycle ack is sampled.
  - imem_ack is ignored while imem_req=0.
- Latency:
  - Zero-wait memory (ack in the first req cycle): new IR is visible 2 cycles after load_ir.
  - Each memory wait cycle adds 1.
- stall = load_ir | (state==WAIT), combinational. It is low in IDLE without load_ir.
- ir_valid is cleared when load_ir is accepted and set again on ack.
- IDLE, no load_ir:
  - inc_pc alone: pc<=pc+1.
  - load_pc: if pc_sel==0, or pc_sel==1 with zero_flag==0, then pc<=operand; otherwise pc is unchanged.
  - load_pc and inc_pc in the same cycle: load_pc wins when taken; inc_pc applies when the jump is not taken.
- IDLE, load_ir together with load_pc: load_pc is ignored. The fetch uses the current pc.
- WAIT: load_ir, inc_pc and load_pc are all ignored. The sequencer must hold while stall=1.
- Arithmetic: pc+1 wraps modulo 2^ADDR_W (0xFF->0x00 at ADDR_W=8). operand is zero-extended or truncated to ADDR_W.
- Reset mid-WAIT: imem_req drops immediately (asynchronously) and the in-flight ack is discarded.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering WAIT and increments each WAIT cycle without ack.
  - When the counter reaches TIMEOUT_CYC:
    - imem_req<=0.
    - IR<=16'h0000 (NOP) and ir_valid<=1.
    - pending increment is applied.
    - fetch_err<=1, sticky until reset.
    - FSM returns to IDLE.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter; WAIT holds indefinitely; fetch_err is tied to 0.

Test Plan:
- Reset release, zero-wait memory:
  - Stimulus: load_ir=1, inc_pc=1 with pc=0x00; ack in the first req cycle with rdata=16'h7A05.
  - Response: imem_addr=0x00; opcode=7, imm_mode=1, reg_sel=2, operand=0x05; pc=0x01; stall high for 2 cycles.
- Wait states:
  - Stimulus: ack delayed 3 cycles.
  - Response: imem_req high for 4 cycles with stable addr; load_pc pulsed during WAIT leaves pc unchanged; stall low only after completion.
- Jumps:
  - Stimulus: in IDLE, IR operand=0x40.
    - load_pc, pc_sel=0 -> pc=0x40.
    - load_pc, pc_sel=1, zero_flag=1 -> pc unchanged.
    - load_pc, pc_sel=1, zero_flag=0 -> pc=0x40.
- Wrap:
  - Stimulus: pc=0xFF, fetch with inc_pc.
  - Response: pc=0x00 after ack.
- Reset mid-fetch:
  - Stimulus: reset_n low during WAIT, then ack arrives.
  - Response: imem_req low the same cycle; pc=RESET_PC; IR=0; ack ignored.
- FETCH_TIMEOUT_EN:
  - Stimulus: no ack.
  - Response: after 15 WAIT cycles, req drops, opcode=0, fetch_err=1 and stays 1 through later fetches.
  - Stimulus: ack on cycle 15.
  - Response: normal completion, fetch_err=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR, and the req/ack handshake to instruction memory.
// Define FETCH_TIMEOUT_EN to add the wait-cycle timeout and the sticky fetch_err flag.
module fetch_unit #(
  parameter int unsigned         ADDR_W      = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
  parameter int unsigned         TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_ir,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic              pc_sel,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        opcode,
  output logic              imm_mode,
  output logic [2:0]        reg_sel,
  output logic [7:0]        operand,
  output logic              ir_valid,
  output logic              stall,
  output logic              fetch_err
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       ir_q, ir_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic              pend_q, pend_d;
  logic              jump_taken;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] pc_inc;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  assign jump_taken = load_pc & (~pc_sel | ~zero_flag);
  assign jump_tgt   = ADDR_W'(ir_q[7:0]);
  assign pc_inc     = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    req_d   = req_q;
    pend_d  = pend_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        // A fetch takes priority; any jump in the same cycle is dropped.
        if (load_ir) begin
          state_d = StWait;
          req_d   = 1'b1;
          addr_d  = pc_q;
          pend_d  = inc_pc;
          valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (jump_taken) begin
          pc_d = jump_tgt;
        end else if (inc_pc) begin
          pc_d = pc_inc;
        end
      end
      StWait: begin
        if (imem_ack && req_q) begin
          state_d = StIdle;
          req_d   = 1'b0;
          ir_d    = imem_rdata;
          valid_d = 1'b1;
          if (pend_q) pc_d = pc_inc;
          pend_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          // Give up: hand the sequencer a NOP and flag the error.
          state_d = StIdle;
          req_d   = 1'b0;
          ir_d    = 16'h0000;
          valid_d = 1'b1;
          if (pend_q) pc_d = pc_inc;
          pend_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= 16'h0000;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_addr = addr_q;
  assign imem_req  = req_q;
  assign pc        = pc_q;
  assign opcode    = ir_q[15:12];
  assign imm_mode  = ir_q[11];
  assign reg_sel   = ir_q[10:8];
  assign operand   = ir_q[7:0];
  assign ir_valid  = valid_q;
  assign stall     = load_ir | (state_q == StWait);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: handshake, jumps, wrap, async reset, timeout.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_ir, inc_pc, load_pc, pc_sel, zero_flag;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [7:0]  pc;
  logic [3:0]  opcode;
  logic        imm_mode;
  logic [2:0]  reg_sel;
  logic [7:0]  operand;
  logic        ir_valid, stall, fetch_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .reset_n(reset_n), .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc),
    .pc_sel(pc_sel), .zero_flag(zero_flag), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .opcode(opcode),
    .imm_mode(imm_mode), .reg_sel(reg_sel), .operand(operand), .ir_valid(ir_valid),
    .stall(stall), .fetch_err(fetch_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL rst_pc got %h want 00", pc); end
    checks++; if (opcode !== 4'h0 || operand !== 8'h00) begin
      errors++; $display("FAIL rst_ir got %h/%h want 0/00", opcode, operand); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ir_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", fetch_err); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_zero_wait();
    load_ir = 1'b1; inc_pc = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL zw_stall0 got %b want 1", stall); end
    step();
    load_ir = 1'b0; inc_pc = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h7A05;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++; $display("FAIL zw_req got %b/%h want 1/00", imem_req, imem_addr); end
    checks++; if (stall !== 1'b1 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL zw_stall1 got %b/%b want 1/0", stall, ir_valid); end
    step();
    imem_ack = 1'b0;
    checks++; if (opcode !== 4'h7 || imm_mode !== 1'b1 || reg_sel !== 3'h2 || operand !== 8'h05) begin
      errors++; $display("FAIL zw_ir got %h %b %h %h want 7 1 2 05", opcode, imm_mode, reg_sel, operand); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL zw_pc got %h want 01", pc); end
    checks++; if (imem_req !== 1'b0 || stall !== 1'b0 || ir_valid !== 1'b1) begin
      errors++; $display("FAIL zw_done got %b/%b/%b want 0/0/1", imem_req, stall, ir_valid); end
  endtask

  task automatic test_wait_states();
    load_ir = 1'b1; inc_pc = 1'b1;
    step();
    load_ir = 1'b0; inc_pc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h01 || stall !== 1'b1) begin
        errors++; $display("FAIL ws_hold[%0d] got %b/%h/%b want 1/01/1", i, imem_req, imem_addr, stall); end
      load_pc = (i == 1); pc_sel = 1'b0;
      imem_ack = (i == 3); imem_rdata = (i == 3) ? 16'h1240 : 16'hDEAD;
      step();
      checks++; if (i < 3 && pc !== 8'h01) begin
        errors++; $display("FAIL ws_pc[%0d] got %h want 01", i, pc); end
    end
    load_pc = 1'b0; imem_ack = 1'b0;
    checks++; if (pc !== 8'h02 || operand !== 8'h40 || opcode !== 4'h1) begin
      errors++; $display("FAIL ws_done got %h/%h/%h want 02/40/1", pc, operand, opcode); end
    checks++; if (imem_req !== 1'b0 || stall !== 1'b0 || fetch_err !== 1'b0) begin
      errors++; $display("FAIL ws_idle got %b/%b/%b want 0/0/0", imem_req, stall, fetch_err); end
  endtask

  task automatic test_jumps();
    load_pc = 1'b1; pc_sel = 1'b0; zero_flag = 1'b1;
    step();
    checks++; if (pc !== 8'h40) begin errors++; $display("FAIL jmp_uncond got %h want 40", pc); end
    load_pc = 1'b0; inc_pc = 1'b1;
    step();
    checks++; if (pc !== 8'h41) begin errors++; $display("FAIL inc_only got %h want 41", pc); end
    load_pc = 1'b1; pc_sel = 1'b1; zero_flag = 1'b1; inc_pc = 1'b0;
    step();
    checks++; if (pc !== 8'h41) begin errors++; $display("FAIL jmp_not_taken got %h want 41", pc); end
    inc_pc = 1'b1;
    step();
    checks++; if (pc !== 8'h42) begin errors++; $display("FAIL jmp_nt_inc got %h want 42", pc); end
    zero_flag = 1'b0;
    step();
    checks++; if (pc !== 8'h40) begin errors++; $display("FAIL jmp_taken_inc got %h want 40", pc); end
    load_pc = 1'b0; inc_pc = 1'b0; pc_sel = 1'b0;
    // Ack with no request outstanding must be ignored.
    imem_ack = 1'b1; imem_rdata = 16'hFFFF;
    step();
    imem_ack = 1'b0;
    checks++; if (opcode !== 4'h1 || operand !== 8'h40 || ir_valid !== 1'b1) begin
      errors++; $display("FAIL idle_ack got %h/%h/%b want 1/40/1", opcode, operand, ir_valid); end
  endtask

  task automatic test_fetch_with_jump();
    load_ir = 1'b1; load_pc = 1'b1; pc_sel = 1'b0;
    step();
    load_ir = 1'b0; load_pc = 1'b0;
    checks++; if (imem_addr !== 8'h40 || pc !== 8'h40) begin
      errors++; $display("FAIL ldir_ldpc got %h/%h want 40/40", imem_addr, pc); end
    imem_ack = 1'b1; imem_rdata = 16'h30FF;
    step();
    imem_ack = 1'b0;
    checks++; if (pc !== 8'h40 || operand !== 8'hFF) begin
      errors++; $display("FAIL ldir_noinc got %h/%h want 40/FF", pc, operand); end
  endtask

  task automatic test_wrap();
    load_pc = 1'b1;
    step();
    load_pc = 1'b0;
    checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL wrap_pre got %h want FF", pc); end
    load_ir = 1'b1; inc_pc = 1'b1;
    step();
    load_ir = 1'b0; inc_pc = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h2000;
    step();
    imem_ack = 1'b0;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap got %h want 00", pc); end
  endtask

  task automatic test_reset_mid_fetch();
    inc_pc = 1'b1;
    step();
    load_ir = 1'b1;
    step();
    load_ir = 1'b0; inc_pc = 1'b0;
    checks++; if (imem_req !== 1'b1 || pc !== 8'h01) begin
      errors++; $display("FAIL rmf_pre got %b/%h want 1/01", imem_req, pc); end
    reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || pc !== 8'h00 || opcode !== 4'h0) begin
      errors++; $display("FAIL rmf_async got %b/%h/%h want 0/00/0", imem_req, pc, opcode); end
    imem_ack = 1'b1; imem_rdata = 16'hABCD;
    step();
    reset_n = 1'b1;
    step();
    imem_ack = 1'b0;
    checks++; if (opcode !== 4'h0 || operand !== 8'h00 || ir_valid !== 1'b0 || pc !== 8'h00) begin
      errors++; $display("FAIL rmf_after got %h/%h/%b/%h want 0/00/0/00", opcode, operand, ir_valid, pc); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    load_ir = 1'b1; inc_pc = 1'b1;
    step();
    load_ir = 1'b0; inc_pc = 1'b0;
    for (int i = 0; i < 15; i++) begin
      checks++; if (imem_req !== 1'b1) begin
        errors++; $display("FAIL to_req[%0d] got %b want 1", i, imem_req); end
      step();
    end
    checks++; if (imem_req !== 1'b0 || opcode !== 4'h0 || ir_valid !== 1'b1 || fetch_err !== 1'b1) begin
      errors++; $display("FAIL to_fire got %b/%h/%b/%b want 0/0/1/1", imem_req, opcode, ir_valid, fetch_err); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL to_pc got %h want 01", pc); end
    load_ir = 1'b1;
    step();
    load_ir = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h5123;
    step();
    imem_ack = 1'b0;
    checks++; if (fetch_err !== 1'b1 || opcode !== 4'h5) begin
      errors++; $display("FAIL to_sticky got %b/%h want 1/5", fetch_err, opcode); end
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    step();
    load_ir = 1'b1;
    step();
    load_ir = 1'b0;
    for (int i = 0; i < 15; i++) begin
      imem_ack = (i == 14); imem_rdata = 16'h9AB7;
      step();
    end
    imem_ack = 1'b0;
    checks++; if (fetch_err !== 1'b0 || opcode !== 4'h9 || operand !== 8'hB7 || imem_req !== 1'b0) begin
      errors++; $display("FAIL to_ack15 got %b/%h/%h/%b want 0/9/B7/0", fetch_err, opcode, operand, imem_req); end
  endtask
`endif

  initial begin
    load_ir = 1'b0; inc_pc = 1'b0; load_pc = 1'b0; pc_sel = 1'b0; zero_flag = 1'b0;
    imem_ack = 1'b0; imem_rdata = 16'h0000; reset_n = 1'b1;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_jumps();
    test_fetch_with_jump();
    test_wrap();
    test_reset_mid_fetch();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
